seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
- Decoding end of the seven-segment display path: samples the four active-low segment buses h0..h3 and recovers the 12-bit value shown on them.
- Waits for the display to settle, decodes each digit, flags illegal patterns, and publishes the value with a one-cycle strobe.
- Used as a loopback checker on the ADC readout display and as a bench monitor.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles all four segment buses must hold unchanged before decoding (>=1).
- CNT_W, 8, width of the publish counter update_cnt.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  capture enable
- h0  in  7  segment bus, digit 0 (num[3:0]), active-low, bit0=a .. bit6=g
- h1  in  7  segment bus, digit 1 (num[7:4])
- h2  in  7  segment bus, digit 2 (num[11:8])
- h3  in  7  segment bus, digit 3 (must show blank or '0')
- num  out  12  last successfully decoded value
- num_valid  out  1  one-cycle pulse when num is (re)published
- seg_err  out  1  last decode attempt failed
- err_mask  out  4  per-digit illegal-pattern flags from last attempt
- update_cnt  out  CNT_W  count of successful publishes, wraps

Behaviour:
- Reset (async on reset_n low, any state, mid-operation included):
  - num=0, num_valid=0, seg_err=0, err_mask=0, update_cnt=0.
  - state=SETTLE, stable counter=0, snapshot=all 7'h7F.
- Input stage: {h3,h2,h1,h0} registered every cycle into h_q. Stability compares h_q with its one-cycle-delayed copy.
- Stable counter, width clog2(STABLE_CYCLES+1):
  - Clears to 0 on any mismatch.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM:
  - SETTLE -> DECODE when counter == STABLE_CYCLES.
  - DECODE -> HOLD unconditionally. DECODE lasts exactly 1 cycle and loads the snapshot from h_q.
  - HOLD -> SETTLE when h_q != snapshot. The counter restarts from 0 on that transition.
- enable low: FSM forced to SETTLE, counter held at 0, no num_valid. num, seg_err, err_mask and update_cnt hold their values.
- Decode table (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Any other code is illegal for h0..h2.
- h3 is legal only for 40 ('0') or 7F (blank). Its value is not part of num.
- DECODE outcome:
  - All four digits legal: num <= {d2,d1,d0}, num_valid=1 for that single cycle, seg_err <= 0, err_mask <= 0, update_cnt += 1 (wraps 2^CNT_W-1 -> 0).
  - Otherwise: num unchanged, no pulse, seg_err <= 1, err_mask bit i set for each illegal digit i. Both stay until the next DECODE.
- Latency: num_valid is high in the cycle following edge E+STABLE_CYCLES+2, where E is the first clock edge at which the new pattern is on the inputs.
- A glitch shorter than STABLE_CYCLES produces no pulse. Returning to the same pattern afterwards republishes the same num (duplicate publishes are permitted).
- A change during DECODE is ignored for that decode. It is caught in HOLD on the next cycle.

Decomposition:
- Package seven_seg_pkg:
  - SEG_0..SEG_F constants and SEG_BLANK=7'h7F.
  - State enum {SETTLE, DECODE, HOLD}.
- Sub-module seg_to_hex: combinational 7-bit code -> 4-bit nibble plus legal flag, instantiated four times. h3 legality is checked in the top against SEG_0/SEG_BLANK.

Test Plan:
- Reset with inputs toggling -> num=0, num_valid=0, seg_err=0, err_mask=0, update_cnt=0 throughout reset.
- STABLE_CYCLES=4; h2=79, h1=24, h0=30, h3=7F held -> single num_valid pulse at edge E+6, num=12'h123, update_cnt=1; no further pulses while held.
- Hex letters: h2=08, h1=21, h0=0E, h3=40 -> num=12'hADF, seg_err=0.
- Glitch: h0 changed to 19 for 2 cycles, then back to 30 -> no pulse during glitch; one pulse with num=12'h123 six edges after restore; update_cnt increments.
- Illegal: h1=7F, h3=00 -> seg_err=1, err_mask=4'b1010, num stays 12'h123, no pulse. Then legal pattern -> seg_err=0, err_mask=0, pulse.
- Control: enable low during SETTLE -> no pulse and outputs held. reset_n low mid-SETTLE -> all outputs at reset values. Forced 256 publishes -> update_cnt wraps to 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment capture path: active-low segment codes
// (bit0=a .. bit6=g) and the capture FSM state type.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } cap_state_e;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational decoder: one active-low seven-segment code to a hex nibble.
// Codes outside the sixteen hex glyphs report legal=0 and nibble=0.
module seg_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    // Glyph lookup; anything unrecognised falls to the illegal default.
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers the 12-bit value shown on four active-low segment buses once they have
// been stable for STABLE_CYCLES, publishing it with a one-cycle num_valid strobe.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [6:0]       h0,
    input  logic [6:0]       h1,
    input  logic [6:0]       h2,
    input  logic [6:0]       h3,
    output logic [11:0]      num,
    output logic             num_valid,
    output logic             seg_err,
    output logic [3:0]       err_mask,
    output logic [CNT_W-1:0] update_cnt
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);

    logic [27:0]      h_q, hd_q, snap_q, snap_d;
    logic [SC_W-1:0]  stab_q, stab_d;
    cap_state_e       state_q, state_d;
    logic [11:0]      num_q, num_d;
    logic             num_valid_q, num_valid_d;
    logic             seg_err_q, seg_err_d;
    logic [3:0]       err_mask_q, err_mask_d;
    logic [CNT_W-1:0] update_cnt_q, update_cnt_d;

    logic [3:0]       legal_s;
    logic [11:0]      digits_s;
    logic             mismatch_s;

    seg_to_hex u_dec0 (.seg(h_q[6:0]),   .nibble(digits_s[3:0]),  .legal(legal_s[0]));
    seg_to_hex u_dec1 (.seg(h_q[13:7]),  .nibble(digits_s[7:4]),  .legal(legal_s[1]));
    seg_to_hex u_dec2 (.seg(h_q[20:14]), .nibble(digits_s[11:8]), .legal(legal_s[2]));

    // The leading digit carries no value; it may only be blank or a zero.
    assign legal_s[3] = (h_q[27:21] == SEG_0) || (h_q[27:21] == SEG_BLANK);
    assign mismatch_s = (h_q != hd_q);

    // Next-state logic for the settle counter, FSM and published outputs.
    always_comb begin
        state_d      = state_q;
        stab_d       = stab_q;
        snap_d       = snap_q;
        num_d        = num_q;
        num_valid_d  = 1'b0;
        seg_err_d    = seg_err_q;
        err_mask_d   = err_mask_q;
        update_cnt_d = update_cnt_q;
        if (!enable) begin
            state_d = SETTLE;
            stab_d  = '0;
        end else begin
            if (mismatch_s) begin
                stab_d = '0;
            end else if (stab_q == SC_MAX) begin
                stab_d = stab_q;
            end else begin
                stab_d = stab_q + SC_W'(1);
            end
            case (state_q)
                SETTLE: begin
                    if (stab_q == SC_MAX) begin
                        // Outputs register on entry so the strobe spans the DECODE cycle;
                        // the snapshot is the very pattern that was decoded.
                        state_d = DECODE;
                        snap_d  = h_q;
                        if (&legal_s) begin
                            num_d        = digits_s;
                            num_valid_d  = 1'b1;
                            seg_err_d    = 1'b0;
                            err_mask_d   = 4'b0000;
                            update_cnt_d = update_cnt_q + CNT_W'(1);
                        end else begin
                            seg_err_d  = 1'b1;
                            err_mask_d = ~legal_s;
                        end
                    end else begin
                        state_d = SETTLE;
                    end
                end
                DECODE: begin
                    state_d = HOLD;
                end
                HOLD: begin
                    if (h_q != snap_q) begin
                        state_d = SETTLE;
                        stab_d  = '0;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = SETTLE;
                    stab_d  = '0;
                end
            endcase
        end
    end

    // Input sampling, stability history, FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q          <= {4{SEG_BLANK}};
            hd_q         <= {4{SEG_BLANK}};
            snap_q       <= {4{SEG_BLANK}};
            stab_q       <= '0;
            state_q      <= SETTLE;
            num_q        <= 12'h000;
            num_valid_q  <= 1'b0;
            seg_err_q    <= 1'b0;
            err_mask_q   <= 4'b0000;
            update_cnt_q <= '0;
        end else begin
            h_q          <= {h3, h2, h1, h0};
            hd_q         <= h_q;
            snap_q       <= snap_d;
            stab_q       <= stab_d;
            state_q      <= state_d;
            num_q        <= num_d;
            num_valid_q  <= num_valid_d;
            seg_err_q    <= seg_err_d;
            err_mask_q   <= err_mask_d;
            update_cnt_q <= update_cnt_d;
        end
    end

    assign num        = num_q;
    assign num_valid  = num_valid_q;
    assign seg_err    = seg_err_q;
    assign err_mask   = err_mask_q;
    assign update_cnt = update_cnt_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: a vector table of display patterns plus
// hand-written glitch, enable, mid-operation reset and counter-wrap sequences.
module tb_seven_seg_capture;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 8;
    localparam int PULSE_K       = STABLE_CYCLES + 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [6:0]       h0, h1, h2, h3;
    logic [11:0]      num;
    logic             num_valid;
    logic             seg_err;
    logic [3:0]       err_mask;
    logic [CNT_W-1:0] update_cnt;

    always #5 clk = ~clk;

    seven_seg_capture #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .h0(h0), .h1(h1), .h2(h2), .h3(h3),
        .num(num), .num_valid(num_valid), .seg_err(seg_err),
        .err_mask(err_mask), .update_cnt(update_cnt)
    );

    typedef struct {
        logic [6:0]  s3, s2, s1, s0;
        logic        ok;
        logic [11:0] val;
        logic [3:0]  mask;
    } vec_t;

    vec_t             vecs [10];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [11:0]      model_num;
    logic [CNT_W-1:0] model_cnt;
    int               pulses, first_k, total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] a3, input logic [6:0] a2,
                         input logic [6:0] a1, input logic [6:0] a0);
        h3 = a3; h2 = a2; h1 = a1; h0 = a0;
    endtask

    // Called at a falling edge; k=1 is the first rising edge that sees new inputs.
    task automatic watch(input int n, output int p, output int fk);
        p  = 0;
        fk = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (num_valid === 1'b1) begin
                p++;
                if (fk == 0) fk = k;
            end
        end
    endtask

    task automatic check_held(input string tag, input logic err);
        check({tag, " num"},        32'(num),        32'(model_num));
        check({tag, " seg_err"},    32'(seg_err),    32'(err));
        check({tag, " update_cnt"}, 32'(update_cnt), 32'(model_cnt));
    endtask

    initial begin
        vecs[0] = '{7'h40, 7'h08, 7'h21, 7'h0E, 1'b1, 12'hADF, 4'b0000};
        vecs[1] = '{7'h7F, 7'h79, 7'h24, 7'h30, 1'b1, 12'h123, 4'b0000};
        vecs[2] = '{7'h00, 7'h79, 7'h7F, 7'h30, 1'b0, 12'h000, 4'b1010};
        vecs[3] = '{7'h7F, 7'h46, 7'h12, 7'h02, 1'b1, 12'hC56, 4'b0000};
        vecs[4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, 12'h000, 4'b0111};
        vecs[5] = '{7'h40, 7'h00, 7'h10, 7'h40, 1'b1, 12'h890, 4'b0000};
        vecs[6] = '{7'h40, 7'h03, 7'h19, 7'h78, 1'b1, 12'hB47, 4'b0000};
        vecs[7] = '{7'h7F, 7'h06, 7'h0E, 7'h21, 1'b1, 12'hEFD, 4'b0000};
        vecs[8] = '{7'h7F, 7'h79, 7'h24, 7'h31, 1'b0, 12'h000, 4'b0001};
        vecs[9] = '{7'h7F, 7'h40, 7'h40, 7'h40, 1'b1, 12'h000, 4'b0000};

        // Reset held while the inputs toggle.
        reset_n = 1'b0;
        enable  = 1'b1;
        drive(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("reset outputs c%0d", i),
                  {7'd0, num, num_valid, seg_err, err_mask, update_cnt}, 32'd0);
        end
        model_num = 12'h000;
        model_cnt = '0;

        // Table of patterns, each applied from a settled HOLD.
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0);
            watch(12, pulses, first_k);
            if (vecs[i].ok) begin
                model_num = vecs[i].val;
                model_cnt = model_cnt + CNT_W'(1);
                check($sformatf("v%0d pulse_edge", i), 32'(first_k), 32'(PULSE_K));
            end
            check($sformatf("v%0d pulses", i), 32'(pulses), vecs[i].ok ? 32'd1 : 32'd0);
            check($sformatf("v%0d err_mask", i), 32'(err_mask),
                  vecs[i].ok ? 32'd0 : 32'(vecs[i].mask));
            check_held($sformatf("v%0d", i), !vecs[i].ok);
        end

        // Short glitch on h0, then the original pattern returns.
        drive(7'h7F, 7'h79, 7'h24, 7'h30);
        watch(12, pulses, first_k);
        model_num = 12'h123;
        model_cnt = model_cnt + CNT_W'(1);
        check("pre-glitch pulses", 32'(pulses), 32'd1);
        h0 = 7'h19;
        watch(2, pulses, first_k);
        check("glitch pulses", 32'(pulses), 32'd0);
        h0 = 7'h30;
        watch(12, pulses, first_k);
        model_cnt = model_cnt + CNT_W'(1);
        check("restore pulses", 32'(pulses), 32'd1);
        check("restore pulse_edge", 32'(first_k), 32'(PULSE_K));
        check_held("restore", 1'b0);

        // Enable low: nothing published, outputs hold; re-enable restarts settling.
        enable = 1'b0;
        drive(7'h7F, 7'h19, 7'h12, 7'h02);
        watch(12, pulses, first_k);
        check("disabled pulses", 32'(pulses), 32'd0);
        check_held("disabled", 1'b0);
        enable = 1'b1;
        watch(10, pulses, first_k);
        model_num = 12'h456;
        model_cnt = model_cnt + CNT_W'(1);
        check("reenable pulses", 32'(pulses), 32'd1);
        check("reenable pulse_edge", 32'(first_k), 32'(STABLE_CYCLES + 1));
        check_held("reenable", 1'b0);

        // Asynchronous reset in the middle of settling.
        drive(7'h7F, 7'h78, 7'h00, 7'h10);
        watch(3, pulses, first_k);
        reset_n = 1'b0;
        #1;
        check("midreset outputs", {7'd0, num, num_valid, seg_err, err_mask, update_cnt}, 32'd0);
        watch(2, pulses, first_k);
        check("midreset held", {7'd0, num, num_valid, seg_err, err_mask, update_cnt}, 32'd0);
        reset_n = 1'b1;
        watch(12, pulses, first_k);
        model_num = 12'h789;
        model_cnt = CNT_W'(1);
        check("postreset pulses", 32'(pulses), 32'd1);
        check("postreset pulse_edge", 32'(first_k), 32'(PULSE_K));
        check_held("postreset", 1'b0);

        // Alternate two legal patterns until update_cnt wraps.
        total = 0;
        for (int i = 0; i < 255; i++) begin
            if (i % 2 == 0) drive(7'h7F, 7'h79, 7'h24, 7'h30);
            else            drive(7'h40, 7'h08, 7'h21, 7'h0E);
            watch(8, pulses, first_k);
            total += pulses;
            if (i == 253) check("wrap cnt_255", 32'(update_cnt), 32'd255);
        end
        check("wrap pulses", 32'(total), 32'd255);
        check("wrap cnt_0", 32'(update_cnt), 32'd0);
        check("wrap num", 32'(num), 32'h123);
        check("wrap seg_err", 32'(seg_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
